// File: rtl/cpu_pkg.sv
// Types and widths shared by writeback, regfile and decode.
// Pure declarations: no logic, no latency, no flow control.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int REGW = 5;

  typedef struct packed {
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] data;
    logic            live;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of writeback entries with per-entry WAW kill; state changes on the next edge.
// No internal backpressure: the owner must not push when count==DEPTH or pop when count==0.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  wb_entry_t                  pushEntry,
  input  logic                       pop,
  input  logic                       killEn,
  input  logic [REGW-1:0]            killRd,
  output wb_entry_t                  head,
  output logic [$clog2(DEPTH):0]     count,
  output wb_entry_t                  entries [DEPTH]
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wrPtr;
  logic [AW-1:0]   rdPtr;

  // Popped and empty slots always carry live=0, so the live bits alone
  // describe the outstanding writes without consulting the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (killEn && mem[i].rd == killRd) mem[i].live <= 1'b0;
      end
      if (pop) begin
        mem[rdPtr].live <= 1'b0;
        rdPtr           <= rdPtr + 1'b1;
      end
      if (push) begin
        mem[wrPtr] <= pushEntry;
        wrPtr      <= wrPtr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head    = mem[rdPtr];
  assign entries = mem;
endmodule

// File: rtl/wb_arbiter.sv
// Owns the regfile write port: ALU results first, then queued LSU results, then LSU cut-through; 1-cycle registered output.
// ALU is never stalled; LSU is backpressured by lsu_ready whenever the holding FIFO is full.
module wb_arbiter #(
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int REGW  = cpu_pkg::REGW,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [REGW-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [REGW-1:0] lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            RegWrite,
  output logic [REGW-1:0] WriteRegister,
  output logic [XLEN-1:0] WriteData,
  input  logic [REGW-1:0] QueryReg1,
  input  logic [REGW-1:0] QueryReg2,
  output logic            Pending1,
  output logic            Pending2
);
  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic                aluEff;
  logic                lsuFire;
  logic                fifoEmpty;
  logic                push;
  logic                pop;
  logic                cutThrough;
  logic                selWe;
  logic [REGW-1:0]     selRd;
  logic [XLEN-1:0]     selData;
  wb_entry_t           pushEntry;
  wb_entry_t           head;
  logic [CW-1:0]       count;
  wb_entry_t           entries [DEPTH];

  assign aluEff    = alu_valid && (alu_rd != '0);
  // Ready looks only at the registered count, so a full FIFO stays full
  // for a cycle even if it drains that same cycle.
  assign lsu_ready = !rst && (count < CW'(DEPTH));
  assign lsuFire   = lsu_valid && lsu_ready;
  assign fifoEmpty = (count == '0);

  always_comb begin
    selWe      = 1'b0;
    selRd      = '0;
    selData    = '0;
    pop        = 1'b0;
    cutThrough = 1'b0;
    if (aluEff) begin
      selWe   = 1'b1;
      selRd   = alu_rd;
      selData = alu_data;
    end else if (!fifoEmpty) begin
      pop     = 1'b1;
      selWe   = head.live;
      selRd   = head.rd;
      selData = head.data;
    end else if (lsuFire) begin
      cutThrough = 1'b1;
      selWe      = (lsu_rd != '0);
      selRd      = lsu_rd;
      selData    = lsu_data;
    end
  end

  // A same-cycle ALU write to the same rd is younger, so the LSU entry is born dead.
  assign push           = lsuFire && !cutThrough;
  assign pushEntry.rd   = lsu_rd;
  assign pushEntry.data = lsu_data;
  assign pushEntry.live = (lsu_rd != '0) && !(aluEff && (lsu_rd == alu_rd));

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pushEntry (pushEntry),
    .pop       (pop),
    .killEn    (aluEff),
    .killRd    (alu_rd),
    .head      (head),
    .count     (count),
    .entries   (entries)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      RegWrite <= selWe;
      if (selWe) begin
        WriteRegister <= selRd;
        WriteData     <= selData;
      end
    end
  end

  always_comb begin
    Pending1 = 1'b0;
    Pending2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].live && entries[i].rd == QueryReg1 && QueryReg1 != '0) Pending1 = 1'b1;
      if (entries[i].live && entries[i].rd == QueryReg2 && QueryReg2 != '0) Pending2 = 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: inputs change 1ns after each rising edge,
// combinational outputs are checked then, registered ones after the next edge.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  QueryReg1;
  logic [4:0]  QueryReg2;
  logic        Pending1;
  logic        Pending2;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(32), .REGW(5), .DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .lsu_valid     (lsu_valid),
    .lsu_ready     (lsu_ready),
    .lsu_rd        (lsu_rd),
    .lsu_data      (lsu_data),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .QueryReg1     (QueryReg1),
    .QueryReg2     (QueryReg2),
    .Pending1      (Pending1),
    .Pending2      (Pending2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    alu_valid = av;
    alu_rd    = ar;
    alu_data  = ad;
    lsu_valid = lv;
    lsu_rd    = lr;
    lsu_data  = ld;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic chkWrite(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, ".we"}, 32'(RegWrite), 32'(we));
    chk({tag, ".rd"}, 32'(WriteRegister), 32'(rd));
    chk({tag, ".data"}, WriteData, d);
  endtask

  initial begin
    rst       = 1'b1;
    QueryReg1 = 5'd0;
    QueryReg2 = 5'd0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h1234);

    // Reset held two cycles with an LSU offer present
    step();
    chk("rst.ready0", 32'(lsu_ready), 32'd0);
    chkWrite("rst.c0", 1'b0, 5'd0, 32'h0);
    step();
    chk("rst.ready1", 32'(lsu_ready), 32'd0);
    chkWrite("rst.c1", 1'b0, 5'd0, 32'h0);
    rst = 1'b0;
    idle();
    #1;
    chk("rst.readyAfter", 32'(lsu_ready), 32'd1);

    // ALU write
    drive(1'b1, 5'd2, 32'h8, 1'b0, 5'd0, 32'h0);
    step();
    chkWrite("alu", 1'b1, 5'd2, 32'h8);
    idle();
    step();
    chkWrite("alu.hold", 1'b0, 5'd2, 32'h8);

    // Cut-through
    QueryReg1 = 5'd3;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hDEAD_BEEF);
    #1;
    chk("ct.ready", 32'(lsu_ready), 32'd1);
    chk("ct.pend", 32'(Pending1), 32'd0);
    step();
    idle();
    #1;
    chkWrite("ct", 1'b1, 5'd3, 32'hDEAD_BEEF);
    chk("ct.pendAfter", 32'(Pending1), 32'd0);
    step();
    chk("ct.done", 32'(RegWrite), 32'd0);

    // Contention and backpressure
    QueryReg1 = 5'd9;
    drive(1'b1, 5'd5, 32'h50, 1'b1, 5'd9, 32'h90);
    #1;
    chk("cont.ready1", 32'(lsu_ready), 32'd1);
    step();
    chkWrite("cont.w5", 1'b1, 5'd5, 32'h50);
    drive(1'b1, 5'd6, 32'h60, 1'b1, 5'd10, 32'hA0);
    #1;
    chk("cont.ready2", 32'(lsu_ready), 32'd1);
    chk("cont.pend9a", 32'(Pending1), 32'd1);
    step();
    chkWrite("cont.w6", 1'b1, 5'd6, 32'h60);
    drive(1'b1, 5'd7, 32'h70, 1'b1, 5'd11, 32'hB0);
    #1;
    chk("cont.ready3", 32'(lsu_ready), 32'd0);
    chk("cont.pend9b", 32'(Pending1), 32'd1);
    step();
    chkWrite("cont.w7", 1'b1, 5'd7, 32'h70);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'hB0);
    #1;
    chk("cont.ready4", 32'(lsu_ready), 32'd0);
    step();
    chkWrite("cont.w9", 1'b1, 5'd9, 32'h90);
    #1;
    chk("cont.ready5", 32'(lsu_ready), 32'd1);
    chk("cont.pend9c", 32'(Pending1), 32'd0);
    step();
    idle();
    chkWrite("cont.w10", 1'b1, 5'd10, 32'hA0);
    step();
    chkWrite("cont.w11", 1'b1, 5'd11, 32'hB0);
    step();
    chk("cont.done", 32'(RegWrite), 32'd0);

    // WAW kill of a queued entry
    QueryReg2 = 5'd4;
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd4, 32'hAA);
    step();
    chkWrite("waw.w1", 1'b1, 5'd1, 32'h11);
    drive(1'b1, 5'd4, 32'h1, 1'b0, 5'd0, 32'h0);
    step();
    idle();
    #1;
    chkWrite("waw.w4", 1'b1, 5'd4, 32'h1);
    chk("waw.pend4", 32'(Pending2), 32'd0);
    step();
    chkWrite("waw.deadPop", 1'b0, 5'd4, 32'h1);
    step();
    chk("waw.idle", 32'(RegWrite), 32'd0);

    // Same-cycle WAW: LSU enqueued dead behind the ALU write
    QueryReg1 = 5'd12;
    drive(1'b1, 5'd12, 32'hC, 1'b1, 5'd12, 32'hCC);
    step();
    idle();
    #1;
    chkWrite("waw2.alu", 1'b1, 5'd12, 32'hC);
    chk("waw2.pend", 32'(Pending1), 32'd0);
    step();
    chkWrite("waw2.deadPop", 1'b0, 5'd12, 32'hC);

    // ALU rd0 lets the FIFO drain
    drive(1'b1, 5'd13, 32'hD, 1'b1, 5'd14, 32'hE);
    step();
    chkWrite("rd0.w13", 1'b1, 5'd13, 32'hD);
    drive(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0);
    step();
    idle();
    chkWrite("rd0.w14", 1'b1, 5'd14, 32'hE);
    step();
    chk("rd0.idle", 32'(RegWrite), 32'd0);

    // LSU rd0 cut-through is accepted but never written
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h5);
    #1;
    chk("rd0.lsuReady", 32'(lsu_ready), 32'd1);
    step();
    idle();
    chkWrite("rd0.lsuDrop", 1'b0, 5'd14, 32'hE);

    // Mid-operation reset discards queued entries
    QueryReg1 = 5'd16;
    drive(1'b1, 5'd15, 32'h15, 1'b1, 5'd16, 32'h16);
    step();
    drive(1'b1, 5'd17, 32'h17, 1'b1, 5'd18, 32'h18);
    step();
    chkWrite("mid.w17", 1'b1, 5'd17, 32'h17);
    rst = 1'b1;
    idle();
    #1;
    chk("mid.pendBefore", 32'(Pending1), 32'd1);
    chk("mid.readyRst", 32'(lsu_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chkWrite("mid.rst", 1'b0, 5'd0, 32'h0);
    chk("mid.pendAfter", 32'(Pending1), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("mid.noWrite%0d", i), 32'(RegWrite), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of regfile; it owns the single write port (RegWrite / WriteRegister / WriteData).
- It merges two result sources:
  - Single-cycle ALU results. These have priority and no backpressure.
  - Long-latency LSU/mul-div results. These use a valid/ready handshake and are buffered in a small FIFO while the ALU holds the port.
- Exports pending-write flags so decode can stall on operands still queued.

Parameters:
XLEN, 32, data width
REGW, 5, register index width
DEPTH, 2, LSU holding FIFO entries; power of 2, 2..8

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
alu_valid  in  1  ALU result valid this cycle
alu_rd  in  REGW  ALU destination register
alu_data  in  XLEN  ALU result
lsu_valid  in  1  long-latency result offered
lsu_ready  out  1  arbiter accepts LSU result this cycle
lsu_rd  in  REGW  LSU destination register
lsu_data  in  XLEN  LSU result
RegWrite  out  1  regfile write enable (registered)
WriteRegister  out  REGW  regfile write address (registered)
WriteData  out  XLEN  regfile write data (registered)
QueryReg1  in  REGW  decode source register 1
QueryReg2  in  REGW  decode source register 2
Pending1  out  1  live queued write to QueryReg1
Pending2  out  1  live queued write to QueryReg2

Behaviour:
- Reset (sync, rst=1 at posedge):
  - RegWrite=0, WriteRegister=0, WriteData=0.
  - FIFO emptied (count=0, pointers=0, all kill bits cleared).
  - lsu_ready=0 while rst=1.
  - Reset mid-operation discards all queued entries; nothing reaches regfile.
- Definitions:
  - alu_eff = alu_valid & (alu_rd!=0).
  - lsu_fire = lsu_valid & lsu_ready.
  - lsu_ready = !rst & (count<DEPTH), from registered count only; a pop in the same cycle does not free a slot for a push when full.
- FIFO entry = {rd, data, live}.
- Per-cycle selection, priority order:
  - alu_eff: write ALU result; FIFO does not pop.
  - else FIFO non-empty: pop head; write it if live, else RegWrite=0 for that cycle (dead entry still costs one cycle).
  - else lsu_fire with FIFO empty: cut-through; write LSU result directly and do not enqueue.
  - else RegWrite=0.
- Enqueue rule: lsu_fire enqueues unless cut-through was taken; this includes the case where the ALU holds the port.
- Output timing:
  - Selected write is registered; RegWrite/WriteRegister/WriteData are valid the cycle after selection.
  - Latency is 1 cycle for ALU and cut-through LSU.
  - Latency is ≥2 cycles for queued LSU results.
  - When RegWrite=0, WriteRegister/WriteData hold their previous values.
- Register 0:
  - Writes to rd 0 from either source never assert RegWrite.
  - ALU rd 0 counts as no ALU result, so the FIFO may drain that cycle.
  - LSU rd 0 is accepted and enqueued dead (or dropped on cut-through).
- WAW kill:
  - When alu_eff, every FIFO entry with rd==alu_rd is marked dead.
  - An LSU result enqueued in the same cycle with lsu_rd==alu_rd is enqueued dead; the same-cycle ALU result is the younger one.
- FIFO order: in-order; the pointer wraps modulo DEPTH.
- Pending flags:
  - Pending1/2 are combinational.
  - PendingN = (QueryRegN!=0) & any live FIFO entry has rd==QueryRegN.
  - The registered output stage is not included, since regfile covers it next edge.
- Width: no arithmetic on data; count is clog2(DEPTH)+1 bits and never exceeds DEPTH.

Decomposition:
- Shared package cpu_pkg:
  - XLEN and REGW constants.
  - Typedef wb_entry_t {rd, data, live}.
  - These are shared with regfile and decode.
- One natural sub-module wb_fifo: DEPTH-entry circular buffer of wb_entry_t.
  - Ports: push, pop, kill_rd/kill_en, head, count.
  - Exposes an entry array for the pending compare.
- The arbiter top holds the select logic and the output register.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with lsu_valid=1.
  - Response: lsu_ready=0, RegWrite=0, WriteRegister=0, WriteData=0; lsu_ready=1 the cycle after rst falls.
- ALU write:
  - Stimulus: alu_valid, rd=2, data=32'h8.
  - Response: next cycle RegWrite=1, WriteRegister=2, WriteData=8; the cycle after, RegWrite=0.
- Cut-through:
  - Stimulus: FIFO empty, lsu_valid rd=3 data=32'hDEAD_BEEF, no ALU.
  - Response: lsu_ready=1, next cycle write of rd3 = DEADBEEF, Pending never high.
- Contention and backpressure:
  - Stimulus: ALU rd5, rd6, rd7 on 3 consecutive cycles while LSU offers rd9, then rd10, then rd11.
  - Response:
    - lsu_ready low in the third cycle.
    - Writes in order 5, 6, 7, 9, 10, then 11 once accepted.
    - Pending1 with QueryReg1=9 high until the cycle rd9 is selected.
- WAW kill:
  - Stimulus: lsu rd4 = 0xAA queued behind an ALU write, then ALU rd4 = 0x1.
  - Response: rd4 written with 0x1; the queued entry pops with RegWrite=0; Pending for 4 drops in the ALU cycle.
- rd0 and mid-op reset:
  - Stimulus: ALU rd0 with 1 queued entry; then 2 entries queued followed by rst.
  - Response: the ALU rd0 cycle drains the queued entry and writes it (no rd0 write); after rst, no queued entry is ever written.
